// File: rtl/ara_pkg.sv
// Shared lane types: instruction-ID width and FU index type used by the mask router.
package ara_pkg;

    localparam int unsigned NrVInsn = 8;
    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    // Owner entries are sized for the largest lane, so the table layout does not track NrFUs
    localparam int unsigned MaxFUs = 16;
    typedef logic [$clog2(MaxFUs)-1:0] fu_idx_t;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $unsigned($clog2(num_idx)) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Per-FU mask FIFO: push and pop may share a cycle even when full (the pop frees the slot).
module fifo_v3 #(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;

    dtype            mem_q [DEPTH];
    ptr_t            rd_ptr_q;
    ptr_t            wr_ptr_q;
    logic [CntW-1:0] usage_q;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign empty_o = (usage_q == '0);
    assign full_o  = (usage_q == CntW'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   usage_q <= usage_q + CntW'(1);
                2'b01:   usage_q <= usage_q - CntW'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

    // Storage is data only; validity is carried by usage_q
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Routes tagged mask beats to the FU that owns the beat's instruction ID, with per-FU buffering.
// Optional same-cycle pass-through to an idle, ready FU: define ARA_MASK_ROUTER_BYPASS_EN.
module vfu_mask_router
    import ara_pkg::*;
#(
    parameter int unsigned NrFUs        = 2,
    parameter int unsigned MaskBufDepth = 2,
    parameter type         strb_t       = logic [7:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           bind_valid_i,
    input  vid_t                           bind_id_i,
    input  logic [idx_width(NrFUs)-1:0]    bind_fu_i,
    input  logic [NrFUs-1:0][NrVInsn-1:0]  fu_vinsn_done_i,
    input  strb_t                          mask_i,
    input  vid_t                           mask_id_i,
    input  logic                           mask_valid_i,
    output logic                           mask_ready_o,
    output strb_t [NrFUs-1:0]              fu_mask_o,
    output logic [NrFUs-1:0]               fu_mask_valid_o,
    input  logic [NrFUs-1:0]               fu_mask_ready_i,
    output logic                           bind_conflict_o
);

    logic [NrVInsn-1:0] owned_q;
    logic [NrVInsn-1:0] owned_d;
    fu_idx_t            owner_q [NrVInsn];
    logic [NrVInsn-1:0] done_any;

    logic    fwd;
    logic    hit;
    fu_idx_t target;

    logic [NrFUs-1:0] sel;
    logic [NrFUs-1:0] space;
    logic [NrFUs-1:0] bypass;
    logic [NrFUs-1:0] buf_push;
    logic [NrFUs-1:0] buf_pop;
    logic [NrFUs-1:0] buf_empty;
    logic [NrFUs-1:0] buf_full;
    strb_t [NrFUs-1:0] buf_head;

    always_comb begin
        done_any = '0;
        for (int k = 0; k < NrFUs; k++) done_any = done_any | fu_vinsn_done_i[k];
    end

    // A same-cycle bind overrides a done on the same ID: the ID has been reused
    always_comb begin
        owned_d = owned_q & ~done_any;
        if (bind_valid_i) owned_d[bind_id_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owned_q         <= '0;
            bind_conflict_o <= 1'b0;
        end else begin
            owned_q <= owned_d;
            if (bind_valid_i && owned_q[bind_id_i] && !done_any[bind_id_i])
                bind_conflict_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bind_valid_i) owner_q[bind_id_i] <= fu_idx_t'(bind_fu_i);
    end

    // Lookup sees a bind issued in the same cycle as the beat it tags
    always_comb begin
        fwd    = bind_valid_i && (bind_id_i == mask_id_i);
        target = fwd ? fu_idx_t'(bind_fu_i) : owner_q[mask_id_i];
        hit    = (fwd || owned_q[mask_id_i]) && (32'(target) < NrFUs);
    end

    always_comb begin
        sel             = '0;
        space           = '0;
        bypass          = '0;
        buf_push        = '0;
        buf_pop         = '0;
        fu_mask_valid_o = '0;
        fu_mask_o       = '0;
        for (int k = 0; k < NrFUs; k++) begin
            sel[k]   = (target == fu_idx_t'(k));
            space[k] = !buf_full[k] || (fu_mask_ready_i[k] && !buf_empty[k]);
        end
        mask_ready_o = !rst_i && mask_valid_i && hit && |(sel & space);
        for (int k = 0; k < NrFUs; k++) begin
`ifdef ARA_MASK_ROUTER_BYPASS_EN
            bypass[k] = mask_ready_o && sel[k] && buf_empty[k] && fu_mask_ready_i[k];
`else
            bypass[k] = 1'b0;
`endif
            buf_push[k]        = mask_ready_o && sel[k] && !bypass[k];
            buf_pop[k]         = fu_mask_ready_i[k] && !buf_empty[k];
            fu_mask_valid_o[k] = !buf_empty[k] || bypass[k];
            if (bypass[k])          fu_mask_o[k] = mask_i;
            else if (!buf_empty[k]) fu_mask_o[k] = buf_head[k];
        end
    end

    for (genvar k = 0; k < NrFUs; k++) begin : gen_fu_buf
        fifo_v3 #(
            .DEPTH (MaskBufDepth),
            .dtype (strb_t)
        ) i_mask_buf (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (buf_push[k]),
            .data_i  (mask_i),
            .pop_i   (buf_pop[k]),
            .data_o  (buf_head[k]),
            .empty_o (buf_empty[k]),
            .full_o  (buf_full[k])
        );
    end

endmodule

// File: tb/tb_vfu_mask_router.sv
// Bench for vfu_mask_router: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_vfu_mask_router;
    import ara_pkg::*;

    localparam int NFU   = 2;
    localparam int DEPTH = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          bind_valid;
    vid_t                          bind_id;
    logic [0:0]                    bind_fu;
    logic [NFU-1:0][NrVInsn-1:0]   done;
    logic [7:0]                    mask;
    vid_t                          mask_id;
    logic                          mask_valid;
    logic                          mask_ready;
    logic [NFU-1:0][7:0]           fu_mask;
    logic [NFU-1:0]                fu_valid;
    logic [NFU-1:0]                fu_ready;
    logic                          conflict;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vfu_mask_router #(
        .NrFUs        (NFU),
        .MaskBufDepth (DEPTH),
        .strb_t       (logic [7:0])
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bind_valid_i    (bind_valid),
        .bind_id_i       (bind_id),
        .bind_fu_i       (bind_fu),
        .fu_vinsn_done_i (done),
        .mask_i          (mask),
        .mask_id_i       (mask_id),
        .mask_valid_i    (mask_valid),
        .mask_ready_o    (mask_ready),
        .fu_mask_o       (fu_mask),
        .fu_mask_valid_o (fu_valid),
        .fu_mask_ready_i (fu_ready),
        .bind_conflict_o (conflict)
    );

    typedef struct {
        logic       bv;
        logic [2:0] bid;
        logic       bfu;
        logic       mv;
        logic [7:0] m;
        logic [2:0] mid;
        logic [1:0] rdy;
        logic       emr;
        logic [1:0] efv;
        logic [7:0] em0;
        logic [7:0] em1;
        logic       ecf;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic emr, input logic [1:0] efv,
                           input logic [7:0] em0, input logic [7:0] em1, input logic ecf);
        chk({nm, " mask_ready"}, 32'(mask_ready), 32'(emr));
        chk({nm, " fu_valid"},   32'(fu_valid),   32'(efv));
        chk({nm, " fu_mask0"},   32'(fu_mask[0]), 32'(em0));
        chk({nm, " fu_mask1"},   32'(fu_mask[1]), 32'(em1));
        chk({nm, " conflict"},   32'(conflict),   32'(ecf));
    endtask

    task automatic idle_in();
        bind_valid = 1'b0; bind_id = '0; bind_fu = '0; done = '0;
        mask = '0; mask_id = '0; mask_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] m, input logic [2:0] id);
        mask = m; mask_id = id; mask_valid = 1'b1;
    endtask

    task automatic bind_to(input logic [2:0] id, input logic fu);
        bind_valid = 1'b1; bind_id = id; bind_fu = fu;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        fu_ready = 2'b11;
        idle_in();
        tick();
        @(negedge clk);
        chk_out({nm, " reset"}, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    bit         owned_m [8];
    int         owner_m [8];
    logic [7:0] mq [2][$];
    bit         conf_m;

    initial begin
        idle_in();
        fu_ready = 2'b11;

        //          bv    bid   bfu   mv    m      mid   rdy    emr   efv    em0    em1    ecf
        tbl[0]  = '{1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b1, 8'hA5, 3'd3, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b10, 8'h00, 8'hA5, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h3C, 3'd3, 2'b01, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b01, 1'b0, 2'b10, 8'h00, 8'h3C, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b01, 1'b0, 2'b10, 8'h00, 8'h3C, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b10, 8'h00, 8'h3C, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h77, 3'd6, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 3'd6, 1'b0, 1'b1, 8'h77, 3'd6, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b01, 8'h77, 8'h00, 1'b0};
        tbl[12] = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 2'b11, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1};

        do_reset("init");

        for (int i = 0; i < 14; i++) begin
            idle_in();
            bind_valid = tbl[i].bv; bind_id = tbl[i].bid; bind_fu = tbl[i].bfu;
            mask_valid = tbl[i].mv; mask = tbl[i].m; mask_id = tbl[i].mid;
            fu_ready   = tbl[i].rdy;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), tbl[i].emr, tbl[i].efv, tbl[i].em0, tbl[i].em1, tbl[i].ecf);
            tick();
        end

        // Unbound beat stalls, then a same-cycle bind lets it through
        do_reset("stall");
        for (int i = 0; i < 4; i++) begin
            idle_in(); beat(8'h99, 3'd5);
            @(negedge clk);
            chk($sformatf("stall cyc%0d mask_ready", i), 32'(mask_ready), 32'(0));
            tick();
        end
        idle_in(); beat(8'h99, 3'd5); bind_to(3'd5, 1'b0);
        @(negedge clk);
        chk("stall bind mask_ready", 32'(mask_ready), 32'(1));
        tick();
        idle_in();
        @(negedge clk);
        chk_out("stall out", 1'b0, 2'b01, 8'h99, 8'h00, 1'b0);
        tick();

        // Bind/done collision and conflict flag
        do_reset("conf");
        idle_in(); bind_to(3'd4, 1'b0); tick();
        idle_in(); bind_to(3'd4, 1'b1); done[0][4] = 1'b1; tick();
        idle_in(); beat(8'h44, 3'd4);
        @(negedge clk);
        chk("conf reuse mask_ready", 32'(mask_ready), 32'(1));
        chk("conf reuse flag", 32'(conflict), 32'(0));
        tick();
        idle_in();
        @(negedge clk);
        chk_out("conf reuse route", 1'b0, 2'b10, 8'h00, 8'h44, 1'b0);
        tick();
        idle_in(); bind_to(3'd4, 1'b0); tick();
        idle_in();
        @(negedge clk);
        chk("conf rebind flag", 32'(conflict), 32'(1));
        tick();
        idle_in(); done[1][4] = 1'b1; tick();
        idle_in(); beat(8'h45, 3'd4);
        @(negedge clk);
        chk("conf done clears", 32'(mask_ready), 32'(0));
        chk("conf sticky", 32'(conflict), 32'(1));
        tick();

        // FU0 stalled: its buffer fills while FU1 keeps flowing; then push+pop when full
        do_reset("full");
        fu_ready = 2'b10;
        idle_in(); bind_to(3'd1, 1'b0); tick();
        idle_in(); bind_to(3'd2, 1'b1); tick();
        idle_in(); beat(8'h11, 3'd1); @(negedge clk); chk("full b11", 32'(mask_ready), 32'(1)); tick();
        idle_in(); beat(8'h21, 3'd2); @(negedge clk); chk("full b21", 32'(mask_ready), 32'(1)); tick();
        idle_in(); beat(8'h12, 3'd1); @(negedge clk); chk("full b12", 32'(mask_ready), 32'(1)); tick();
        idle_in(); beat(8'h22, 3'd2); @(negedge clk); chk("full b22", 32'(mask_ready), 32'(1)); tick();
        idle_in(); beat(8'h13, 3'd1);
        @(negedge clk);
        chk("full b13 blocked", 32'(mask_ready), 32'(0));
        chk("full head valid", 32'(fu_valid[0]), 32'(1));
        chk("full head hold", 32'(fu_mask[0]), 32'(8'h11));
        tick();
        idle_in(); beat(8'h23, 3'd2); @(negedge clk); chk("full fu1 flows", 32'(mask_ready), 32'(1)); tick();
        fu_ready = 2'b11;
        idle_in(); beat(8'h13, 3'd1);
        @(negedge clk);
        chk("full pushpop ready", 32'(mask_ready), 32'(1));
        chk("full pushpop head", 32'(fu_mask[0]), 32'(8'h11));
        tick();
        fu_ready = 2'b10;
        idle_in(); beat(8'h14, 3'd1);
        @(negedge clk);
        chk("full still full", 32'(mask_ready), 32'(0));
        chk("full order 12", 32'(fu_mask[0]), 32'(8'h12));
        tick();
        fu_ready = 2'b11;
        idle_in(); @(negedge clk); chk("full order 12 pop", 32'(fu_mask[0]), 32'(8'h12)); tick();
        idle_in(); @(negedge clk); chk("full order 13", 32'(fu_mask[0]), 32'(8'h13)); tick();
        idle_in(); @(negedge clk); chk("full drained", 32'(fu_valid[0]), 32'(0)); tick();

        // Mid-operation reset flushes buffers and the table
        do_reset("mid");
        fu_ready = 2'b00;
        idle_in(); bind_to(3'd1, 1'b0); tick();
        idle_in(); beat(8'h31, 3'd1); tick();
        idle_in(); beat(8'h32, 3'd1); tick();
        idle_in();
        @(negedge clk);
        chk("mid buffered", 32'(fu_valid), 32'(2'b01));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk_out("mid in reset", 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        fu_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            idle_in(); beat(8'h33, 3'd1);
            @(negedge clk);
            chk($sformatf("mid unbound%0d", i), 32'(mask_ready), 32'(0));
            chk($sformatf("mid empty%0d", i), 32'(fu_valid), 32'(0));
            tick();
        end
        idle_in(); beat(8'h33, 3'd1); bind_to(3'd1, 1'b0);
        @(negedge clk);
        chk("mid rebind", 32'(mask_ready), 32'(1));
        tick();
        idle_in();
        @(negedge clk);
        chk_out("mid new beat", 1'b0, 2'b01, 8'h33, 8'h00, 1'b0);
        tick();

        // Random traffic against a queue-based ownership model
        do_reset("rand");
        for (int i = 0; i < 8; i++) owned_m[i] = 1'b0;
        mq[0].delete(); mq[1].delete();
        conf_m = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit         ev [2];
            logic [7:0] eh [2];
            bit         pop [2];
            bit         fwd, h, emr;
            int         t;
            bit         done_any [8];
            idle_in();
            bind_valid = ($urandom_range(0, 3) == 0);
            bind_id    = 3'($urandom_range(0, 7));
            bind_fu    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 5) == 0) done[k][$urandom_range(0, 7)] = 1'b1;
            mask_valid = ($urandom_range(0, 3) != 0);
            mask       = 8'($urandom);
            mask_id    = 3'($urandom_range(0, 7));
            fu_ready   = 2'($urandom);

            for (int k = 0; k < 2; k++) begin
                ev[k]  = (mq[k].size() > 0);
                eh[k]  = ev[k] ? mq[k][0] : 8'h00;
                pop[k] = ev[k] && fu_ready[k];
            end
            fwd = bind_valid && (bind_id == mask_id);
            h   = fwd || owned_m[mask_id];
            t   = fwd ? int'(bind_fu) : owner_m[mask_id];
            emr = mask_valid && h && ((mq[t].size() < DEPTH) || pop[t]);

            @(negedge clk);
            chk_out($sformatf("rand%0d", cyc), emr, {ev[1], ev[0]}, eh[0], eh[1], conf_m);

            for (int k = 0; k < 2; k++) if (pop[k]) void'(mq[k].pop_front());
            if (emr) mq[t].push_back(mask);
            for (int id = 0; id < 8; id++) done_any[id] = done[0][id] || done[1][id];
            if (bind_valid && owned_m[bind_id] && !done_any[bind_id]) conf_m = 1'b1;
            for (int id = 0; id < 8; id++) if (done_any[id]) owned_m[id] = 1'b0;
            if (bind_valid) begin
                owned_m[bind_id] = 1'b1;
                owner_m[bind_id] = int'(bind_fu);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
